// File: rtl/jesd_tx_pkg.sv
// Shared lane geometry, filler value and JESD204C byte-order helper for the TX unflattener.
package jesd_tx_pkg;

   localparam int LANES_PER_WORD = 4;
   localparam int LANE_W         = 32;
   localparam logic [LANE_W-1:0] FILLER_LANE = 32'h0;

   typedef logic [1:0] lane_idx_t;

   // Byte swap inside each 16-bit half; the halves keep their positions.
   function automatic logic [LANE_W-1:0] swap16(input logic [LANE_W-1:0] lane);
      return {lane[23:16], lane[31:24], lane[7:0], lane[15:8]};
   endfunction

endpackage

// File: rtl/jesd_tx_word_buffer.sv
// Two-entry word FIFO in front of the lane serializer; no fall-through when full.
module jesd_tx_word_buffer
   import jesd_tx_pkg::*;
#(
   parameter int W = LANE_W * LANES_PER_WORD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   cnt,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] r_mem [0:1];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (push) r_wr_ptr <= ~r_wr_ptr;
         if (pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({push, pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is data only; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   assign head  = r_mem[r_rd_ptr];
   assign cnt   = r_cnt;
   assign full  = (r_cnt == 2'd2);
   assign empty = (r_cnt == 2'd0);

endmodule

// File: rtl/jesd_stream_unflattener_128_32.sv
// 128-bit AXI-Stream to 32-bit JESD204C TX lane serializer with filler/underflow reporting.
// Optional saturating underflow counter enabled by JESD_TX_UNDERFLOW_CNT_EN.
module jesd_stream_unflattener_128_32
   import jesd_tx_pkg::*;
#(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [OUT_W-1:0] m_axis_tdata,
   input  logic             m_axis_tready,
   output logic             underflow
`ifdef JESD_TX_UNDERFLOW_CNT_EN
   ,
   output logic [31:0]      underflow_count,
   input  logic             underflow_clr
`endif
);

   logic [IN_W-1:0]  w_head;
   logic [1:0]       w_cnt;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_advance;
   logic [OUT_W-1:0] w_lane;

   logic [OUT_W-1:0] r_lane;
   logic             r_filler;
   lane_idx_t        r_idx;
   logic             r_underflow;

   assign s_axis_tready = (w_cnt != 2'd2);
   assign w_push        = s_axis_tvalid && !w_full;
   // A filler lane is never held, so the register refills as soon as data exists.
   assign w_advance     = m_axis_tready || r_filler;
   assign w_pop         = w_advance && !w_empty && (r_idx == 2'd3);
   assign w_lane        = w_head[r_idx*OUT_W +: OUT_W];

   jesd_tx_word_buffer #(
      .W     (IN_W)
   ) u_buf (
      .clk   (aclk),
      .rst_n (aresetn),
      .push  (w_push),
      .pop   (w_pop),
      .din   (s_axis_tdata),
      .head  (w_head),
      .cnt   (w_cnt),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_lane      <= FILLER_LANE;
         r_filler    <= 1'b1;
         r_idx       <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= m_axis_tready && r_filler;
         if (w_advance) begin
            if (!w_empty) begin
               r_lane   <= swap16(w_lane);
               r_filler <= 1'b0;
               r_idx    <= r_idx + 2'd1;
            end else begin
               r_lane   <= FILLER_LANE;
               r_filler <= 1'b1;
            end
         end
      end
   end

   assign m_axis_tdata = r_lane;
   assign underflow    = r_underflow;

`ifdef JESD_TX_UNDERFLOW_CNT_EN
   logic [31:0] r_uf_cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_uf_cnt <= 32'd0;
      end else if (underflow_clr) begin
         r_uf_cnt <= 32'd0;
      end else if (r_underflow && (r_uf_cnt != 32'hFFFF_FFFF)) begin
         r_uf_cnt <= r_uf_cnt + 32'd1;
      end
   end

   assign underflow_count = r_uf_cnt;
`endif

endmodule

// File: tb/tb_jesd_stream_unflattener_128_32.sv
// Scoreboard bench for the 128->32 JESD TX unflattener (optional JESD_TX_UNDERFLOW_CNT_EN counter).
module tb_jesd_stream_unflattener_128_32;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [127:0] s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [31:0]  m_axis_tdata;
   logic         m_axis_tready;
   logic         underflow;
`ifdef JESD_TX_UNDERFLOW_CNT_EN
   logic [31:0]  underflow_count;
   logic         underflow_clr;
`endif

   always #5 aclk = ~aclk;

   jesd_stream_unflattener_128_32 dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tready   (m_axis_tready),
      .underflow       (underflow)
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      ,
      .underflow_count (underflow_count),
      .underflow_clr   (underflow_clr)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] sb_q [$];
   int pushed     = 0;
   int n_real     = 0;
   int n_fill     = 0;
   int streak     = 0;
   int max_streak = 0;
   bit in_stream  = 0;
   int push_base  = 0;
   int real_base  = 0;
   bit          pend      = 0;
   logic [31:0] pend_data = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected JESD lane built byte by byte: output byte pairs (1,0) and (3,2) swapped.
   function automatic logic [31:0] exp_lane(input logic [127:0] w, input int i);
      logic [7:0] b [4];
      for (int k = 0; k < 4; k++) b[k] = w[32*i + 8*k +: 8];
      return {b[2], b[3], b[0], b[1]};
   endfunction

   task automatic push_word(input logic [127:0] w);
      int guard;
      guard = 0;
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && guard < 200) begin
         @(negedge aclk);
         guard++;
      end
      if (!s_axis_tready) begin
         check_eq("push_timeout", 64'(guard), 64'd0);
         s_axis_tvalid = 1'b0;
         return;
      end
      @(posedge aclk);
      for (int i = 0; i < 4; i++) sb_q.push_back(exp_lane(w, i));
      pushed++;
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 300) begin
         @(negedge aclk);
         guard++;
      end
      @(negedge aclk);
      check_eq(tag, 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: a lane consumed at an edge is classified one cycle later by the underflow pulse.
   always @(negedge aclk) begin
      #1;
      if (!aresetn) begin
         sb_q.delete();
         pend = 0;
      end else begin
         if (pend) begin
            if (underflow) begin
               check_eq("filler_data", 64'(pend_data), 64'd0);
               n_fill++;
               streak = 0;
            end else begin
               if (sb_q.size() == 0) begin
                  check_eq("sb_unexpected_lane", 64'(pend_data), 64'hDEAD);
               end else begin
                  check_eq("lane", 64'(pend_data), 64'(sb_q.pop_front()));
               end
               n_real++;
               streak++;
               if (streak > max_streak) max_streak = streak;
            end
         end else begin
            check_eq("uf_spurious", 64'(underflow), 64'd0);
         end
         pend      = m_axis_tready;
         pend_data = m_axis_tdata;
         if (in_stream) begin
            if (!s_axis_tready)
               check_eq("strm_full", 64'((pushed - push_base) - (n_real - real_base) / 4 >= 2), 64'd1);
            else
               check_eq("strm_room", 64'((pushed - push_base) - (n_real - real_base + 1) / 4 <= 1), 64'd1);
         end
      end
   end

   initial begin
      logic [127:0] w;
      logic [127:0] wa;
      logic [127:0] w3;
      int uf_seen;
      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      underflow_clr = 1'b0;
`endif

      repeat (3) @(negedge aclk);
      check_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
      check_eq("rst_sready", 64'(s_axis_tready), 64'd1);
      check_eq("rst_uf", 64'(underflow), 64'd0);
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      check_eq("rst_ufcnt", 64'(underflow_count), 64'd0);
`endif
      aresetn = 1'b1;
      @(negedge aclk);

      // Single-word serialization against fixed lane values.
      m_axis_tready = 1'b1;
      repeat (2) @(negedge aclk);
      push_word(128'h0F0E0D0C_0B0A0908_07060504_03020100);
      check_eq("sw_pre", 64'(m_axis_tdata), 64'd0);
      @(negedge aclk); check_eq("sw_l0", 64'(m_axis_tdata), 64'h02030001);
      @(negedge aclk); check_eq("sw_l1", 64'(m_axis_tdata), 64'h06070405);
      @(negedge aclk); check_eq("sw_l2", 64'(m_axis_tdata), 64'h0A0B0809);
      @(negedge aclk); check_eq("sw_l3", 64'(m_axis_tdata), 64'h0E0F0C0D);
      @(negedge aclk); check_eq("sw_post", 64'(m_axis_tdata), 64'd0);
      drain("sw_drain");

      // Streaming: 8 back-to-back words with the sink always ready.
      push_base  = pushed;
      real_base  = n_real;
      max_streak = 0;
      in_stream  = 1;
      for (int i = 0; i < 8; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         push_word(w);
      end
      drain("strm_drain");
      in_stream = 0;
      check_eq("strm_streak", 64'(max_streak), 64'd32);

      // Backpressure mid-word at lane index 2.
      wa = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
      fork
         begin
            push_word(wa);
            push_word({$urandom, $urandom, $urandom, $urandom});
            push_word({$urandom, $urandom, $urandom, $urandom});
         end
         begin
            int pb;
            pb = pushed;
            wait (pushed == pb + 1);
            repeat (3) @(negedge aclk);
            check_eq("bp_lane1", 64'(m_axis_tdata), 64'(exp_lane(wa, 1)));
            m_axis_tready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge aclk);
               check_eq("bp_hold", 64'(m_axis_tdata), 64'(exp_lane(wa, 1)));
               check_eq("bp_sready", 64'(s_axis_tready), 64'd0);
            end
            m_axis_tready = 1'b1;
         end
      join
      drain("bp_drain");

      // Underflow: sink ready for exactly 10 edges on an empty buffer.
      m_axis_tready = 1'b0;
      repeat (3) @(negedge aclk);
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      underflow_clr = 1'b1;
      @(negedge aclk);
      underflow_clr = 1'b0;
      @(negedge aclk);
      check_eq("ufcnt_pre", 64'(underflow_count), 64'd0);
`endif
      uf_seen = 0;
      m_axis_tready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         if (k == 9) m_axis_tready = 1'b0;
         if (underflow) uf_seen++;
      end
      @(negedge aclk);
      check_eq("uf_tail", 64'(underflow), 64'd0);
      check_eq("uf_pulses", 64'(uf_seen), 64'd10);
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      repeat (2) @(negedge aclk);
      check_eq("ufcnt_10", 64'(underflow_count), 64'd10);
      underflow_clr = 1'b1;
      @(negedge aclk);
      underflow_clr = 1'b0;
      @(negedge aclk);
      check_eq("ufcnt_clr", 64'(underflow_count), 64'd0);
`endif

      // Mid-word reset at lane index 1 with a second word buffered.
      m_axis_tready = 1'b1;
      w = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      push_word(w);
      push_word(128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF);
      check_eq("mr_pre", 64'(m_axis_tdata), 64'(exp_lane(w, 0)));
      aresetn = 1'b0;
      #1;
      check_eq("mr_tdata", 64'(m_axis_tdata), 64'd0);
      check_eq("mr_sready", 64'(s_axis_tready), 64'd1);
      check_eq("mr_uf", 64'(underflow), 64'd0);
`ifdef JESD_TX_UNDERFLOW_CNT_EN
      check_eq("mr_ufcnt", 64'(underflow_count), 64'd0);
`endif
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      w3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
      push_word(w3);
      @(negedge aclk);
      check_eq("mr_lane0", 64'(m_axis_tdata), 64'(exp_lane(w3, 0)));
      drain("mr_drain");

      repeat (3) @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
